// File: rtl/trd_icache.sv
// rtl/trd_icache.sv - direct-mapped blocking-refill instruction cache
// Lookup is combinational on the current arrays; one refill engine fetches a line word by word.
module trd_icache #(
  parameter int unsigned LINES     = 16,
  parameter int unsigned WORDS     = 4,
  parameter logic [31:0] MEM_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_rd,
  input  logic [2:0]  i_trd,
  output logic [31:0] i_rd_data,
  output logic        i_miss,
  output logic        i_segfault,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_valid,
  output logic        fill_busy,
  output logic [2:0]  fill_trd,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   k_q, k_d;
  logic               pend_q, pend_d;
  logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]   fill_tag_q, fill_tag_d;
  logic [2:0]         fill_trd_q, fill_trd_d;
  logic [31:0]        hit_cnt_q, hit_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [TAG_W-1:0]   tag_d [LINES];
  logic [31:0]        data_q [LINES][WORDS];
  logic [31:0]        data_d [LINES][WORDS];

  logic [OFF_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               lk_seg, lk_hit, lk_miss, fill_start;

  assign req_off = i_addr[OFF_W+1:2];
  assign req_idx = i_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag = i_addr[31:OFF_W+IDX_W+2];

  // Lookup sees the pre-edge arrays, so a word written this cycle is never returned.
  always_comb begin
    lk_seg     = i_rd & ((i_addr >= MEM_LIMIT) | (i_addr[1:0] != 2'b00));
    lk_hit     = i_rd & ~lk_seg & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    lk_miss    = i_rd & ~lk_seg & ~lk_hit;
    fill_start = lk_miss & (state_q == S_IDLE) & ~flush;
    i_segfault = lk_seg;
    i_miss     = lk_miss;
    i_rd_data  = lk_hit ? data_q[req_idx][req_off] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      pend_q     <= 1'b0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      fill_trd_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      pend_q     <= pend_d;
      fill_idx_q <= fill_idx_d;
      fill_tag_q <= fill_tag_d;
      fill_trd_q <= fill_trd_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Line storage needs no reset: nothing is visible until its valid bit is set.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pend_d     = pend_q;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    fill_trd_d = fill_trd_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    hit_cnt_d  = hit_cnt_q + {31'd0, lk_hit};
    miss_cnt_d = miss_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          state_d          = S_REQ;
          k_d              = '0;
          fill_idx_d       = req_idx;
          fill_tag_d       = req_tag;
          fill_trd_d       = i_trd;
          valid_d[req_idx] = 1'b0;
          miss_cnt_d       = miss_cnt_q + 32'd1;
        end
      end
      S_REQ: begin
        if (flush) begin
          state_d = S_DRAIN;
          pend_d  = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_valid) begin
          data_d[fill_idx_q][k_q] = mem_rd_data;
          if (k_q == OFF_W'(WORDS - 1)) begin
            tag_d[fill_idx_q]   = fill_tag_q;
            valid_d[fill_idx_q] = 1'b1;
            state_d             = S_IDLE;
          end else begin
            k_d     = k_q + OFF_W'(1);
            state_d = S_REQ;
          end
        end
        // A response arriving with the flush is consumed here, so DRAIN has nothing to wait for.
        if (flush) begin
          state_d = S_DRAIN;
          pend_d  = ~mem_valid;
        end
      end
      S_DRAIN: begin
        if (!pend_q || mem_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_addr  = 32'h0;
    fill_busy = (state_q != S_IDLE);
    if (state_q == S_REQ && !flush) begin
      mem_rd   = 1'b1;
      mem_addr = {fill_tag_q, fill_idx_q, k_q, 2'b00};
    end
  end

  assign fill_trd = fill_trd_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_trd_icache.sv
// tb/tb_trd_icache.sv - scoreboard bench for trd_icache
// Driver pushes per-cycle expectations from a line-level cache model; a monitor pops and compares.
module tb_trd_icache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr;
  logic        i_rd;
  logic [2:0]  i_trd;
  logic [31:0] i_rd_data;
  logic        i_miss;
  logic        i_segfault;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rd_data;
  logic        mem_valid;
  logic        fill_busy;
  logic [2:0]  fill_trd;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always #5 clk = ~clk;

  trd_icache dut (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd),
    .i_rd_data(i_rd_data), .i_miss(i_miss), .i_segfault(i_segfault), .flush(flush),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rd_data(mem_rd_data), .mem_valid(mem_valid),
    .fill_busy(fill_busy), .fill_trd(fill_trd), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        miss;
    logic        seg;
    logic        mrd;
    logic [31:0] maddr;
    logic        busy;
    logic [2:0]  trd;
    logic [31:0] hits;
    logic [31:0] misses;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Cache model: per line only valid + tag; a valid line always holds memory contents.
  bit          m_lv [16];
  logic [23:0] m_ltag [16];
  bit          m_busy, m_reqph, m_abort, m_pend;
  int          m_got;
  logic [31:0] m_fbase;
  logic [2:0]  m_ftrd;
  logic [31:0] m_hits, m_misses;

  bit          mpend;
  int          mdue;
  logic [31:0] mpaddr;
  int          lat;
  bit          rand_lat;
  int          cyc;
  logic [31:0] rd_log[$];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_lv[i]   = 1'b0;
      m_ltag[i] = '0;
    end
    m_busy = 0; m_reqph = 0; m_abort = 0; m_pend = 0; m_got = 0;
    m_fbase = '0; m_ftrd = '0; m_hits = '0; m_misses = '0;
    mpend = 0;
  endtask

  task automatic model_update(input bit hit, input bit miss, input bit mv, input logic [3:0] idx);
    bit start;
    start = miss && !m_busy && !flush;
    if (m_busy) begin
      if (m_abort) begin
        if (!m_pend || mv) m_busy = 0;
      end else if (m_reqph) begin
        if (flush) begin m_abort = 1; m_pend = 0; end
        else m_reqph = 0;
      end else begin
        if (mv) begin
          m_got++;
          if (m_got == 4) begin
            if (!flush) begin
              m_lv[m_fbase[7:4]]   = 1'b1;
              m_ltag[m_fbase[7:4]] = m_fbase[31:8];
              m_busy = 0;
            end
          end else begin
            m_reqph = 1;
          end
        end
        if (flush) begin m_abort = 1; m_pend = !mv; end
      end
    end else if (start) begin
      m_busy = 1; m_reqph = 1; m_got = 0; m_abort = 0;
      m_fbase = {i_addr[31:4], 4'b0000};
      m_ftrd = i_trd;
      m_lv[idx] = 1'b0;
      m_misses++;
    end
    if (hit) m_hits++;
    if (flush) for (int i = 0; i < 16; i++) m_lv[i] = 1'b0;
  endtask

  task automatic cycle();
    exp_t        e;
    bit          seg, hit, miss, mv, dmrd;
    logic [3:0]  idx;
    logic [31:0] dmaddr;
    if (mpend && cyc >= mdue) begin
      mem_valid = 1'b1; mem_rd_data = memw(mpaddr); mpend = 0;
    end else begin
      mem_valid = 1'b0; mem_rd_data = $urandom;
    end
    mv   = mem_valid;
    idx  = i_addr[7:4];
    seg  = i_rd && (i_addr >= 32'h0001_0000 || i_addr[1:0] != 2'b00);
    hit  = i_rd && !seg && m_lv[idx] && (m_ltag[idx] == i_addr[31:8]);
    miss = i_rd && !seg && !hit;
    if (rst_n) begin
      e.data   = hit ? memw({i_addr[31:2], 2'b00}) : 32'h0;
      e.miss   = miss;
      e.seg    = seg;
      e.mrd    = m_busy && !m_abort && m_reqph && !flush;
      e.maddr  = m_fbase + 32'(4 * m_got);
      e.busy   = m_busy;
      e.trd    = m_ftrd;
      e.hits   = m_hits;
      e.misses = m_misses;
      sb.push_back(e);
    end
    @(negedge clk);
    dmrd   = mem_rd;
    dmaddr = mem_addr;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      model_update(hit, miss, mv, idx);
      if (dmrd) begin
        mpend  = 1;
        mdue   = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
        mpaddr = dmaddr;
        rd_log.push_back(dmaddr);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input bit rd, input logic [31:0] a, input logic [2:0] t, input bit fl);
    i_rd = rd; i_addr = a; i_trd = t; flush = fl;
    cycle();
  endtask

  task automatic wait_free();
    int n;
    n = 0;
    while (fill_busy && n < 200) begin
      drive(0, 32'h0, 3'd0, 0);
      n++;
    end
    if (n >= 200) cmp("refill_timeout", 1, 0);
  endtask

  function automatic logic [31:0] rnd_addr();
    int          r, tsel;
    logic [31:0] a;
    r    = $urandom_range(0, 99);
    tsel = $urandom_range(0, 3);
    a = {16'h0, (tsel == 3) ? 8'hFF : 8'(tsel), 4'($urandom_range(0, 15)),
         2'($urandom_range(0, 3)), 2'b00};
    if (r < 4) a = 32'h0001_0000 + {a[29:0], 2'b00};
    else if (r < 8) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cmp("resp", {i_rd_data, i_miss, i_segfault}, {e.data, e.miss, e.seg});
        cmp("fill", {mem_rd, mem_rd ? mem_addr : 32'h0, fill_busy, fill_trd},
                    {e.mrd, e.mrd ? e.maddr : 32'h0, e.busy, e.trd});
        cmp("counters", {hit_cnt, miss_cnt}, {e.hits, e.misses});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 0; i_rd = 0; i_addr = 0; i_trd = 0; flush = 0;
    mem_valid = 0; mem_rd_data = 0;
    cyc = 0; lat = 3; rand_lat = 0;
    model_reset();
    repeat (3) cycle();
    rst_n = 1;
    cmp("rst_busy", fill_busy, 0);
    cmp("rst_cnt", {hit_cnt, miss_cnt}, 0);

    // Cold miss with concurrent misses from other threads
    drive(1, 32'h40, 3'd2, 0);
    cmp("cold_fill_trd", fill_trd, 3'd2);
    drive(1, 32'h100, 3'd5, 0);
    drive(1, 32'h40, 3'd3, 0);
    n = 0;
    while (fill_busy && n < 200) begin drive(0, 0, 0, 0); n++; end
    cmp("cold_busy_cycles", 2 + n, 16);
    cmp("single_refill", miss_cnt, 1);
    cmp("cold_rd_count", rd_log.size(), 4);
    if (rd_log.size() == 4)
      cmp("cold_addrs", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]},
          {32'h40, 32'h44, 32'h48, 32'h4C});
    drive(1, 32'h44, 3'd2, 0);
    cmp("retry_hit_cnt", hit_cnt, 1);
    drive(1, 32'h100, 3'd5, 0);
    cmp("refill2_trd", fill_trd, 3'd5);
    wait_free();

    // Conflict eviction on index 4
    drive(1, 32'h140, 3'd1, 0);
    wait_free();
    cmp("conflict_miss_cnt", miss_cnt, 3);
    drive(1, 32'h40, 3'd1, 0);
    cmp("evicted_miss_cnt", miss_cnt, 4);
    wait_free();

    // Segfaults change nothing
    drive(1, 32'h0001_0000, 3'd0, 0);
    drive(1, 32'h42, 3'd0, 0);
    drive(0, 0, 0, 0);
    cmp("seg_counters", {hit_cnt, miss_cnt}, {32'd1, 32'd4});
    cmp("seg_no_rd", rd_log.size(), 16);

    // Flush during the second word's wait
    drive(1, 32'h200, 3'd0, 0);
    n = 0;
    while (!(m_busy && !m_abort && !m_reqph && m_got == 1) && n < 50) begin
      drive(0, 0, 0, 0); n++;
    end
    drive(1, 32'h48, 3'd0, 1);
    wait_free();
    cmp("flush_rd_count", rd_log.size(), 18);
    drive(1, 32'h48, 3'd0, 0);
    wait_free();

    // Reset in the middle of a refill
    drive(1, 32'h300, 3'd6, 0);
    drive(0, 0, 0, 0);
    rst_n = 0;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    rst_n = 1;
    cmp("midrst_idle", {fill_busy, mem_rd}, 0);
    cmp("midrst_cnt", {hit_cnt, miss_cnt}, 0);
    drive(1, 32'h40, 3'd3, 0);
    cmp("midrst_miss_cnt", miss_cnt, 1);
    wait_free();

    // Random traffic with variable memory latency
    rand_lat = 1;
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 9) < 7, rnd_addr(), 3'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 2);
    end
    wait_free();
    drive(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
